// File: rtl/uart_tx_fifo.sv
// Byte-wide TX FIFO feeding an 8N1 UART transmitter with a registered serial output.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

  // Full comes from the registered count, so a write during a pop while full is still dropped.
  assign push    = wr_en && !full;
  assign bit_end = (bit_cnt_q == 16'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // The popped byte is captured here so later FIFO writes cannot disturb the frame.
    if (pop) begin
      state_d   = START;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
      shift_d   = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
      par_d     = ^mem_q[rptr_q];
`endif
    end

    busy_d     = (state_d != IDLE);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | (wr_en & full);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=8) with a mid-bit sampling UART monitor.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, busy, tx;
  logic [3:0] level;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] mon_q[$];
  logic       mon_par[$];
  int         mon_err = 0;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Independent line decoder: samples each bit in the middle of its CLK_DIV window.
  initial begin : monitor
    logic [7:0] d;
    logic       p, s;
    d = '0;
    forever begin
      @(posedge clk); #2;
      if (tx === 1'b0) begin
        repeat (CLK_DIV/2) @(posedge clk);
        #2;
        if (tx !== 1'b0) mon_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          #2;
          d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CLK_DIV) @(posedge clk);
        #2;
        p = tx;
        if (p !== ^d) mon_err++;
        mon_par.push_back(p);
`endif
        repeat (CLK_DIV) @(posedge clk);
        #2;
        s = tx;
        if (s !== 1'b1) mon_err++;
        mon_q.push_back(d);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0;
    step(); step();
    n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (level !== 4'd0)   begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    step(); step();
  endtask

  task automatic test_single();
    logic [10:0] fb;
    mon_q.delete(); mon_par.delete(); mon_err = 0;
    fb = '1; fb[0] = 1'b0; fb[8:1] = 8'h55;
`ifdef UART_TX_PARITY_EN
    fb[9] = ^8'h55;
`endif
    wr_data = 8'h55; wr_en = 1'b1;
    step(); wr_en = 1'b0;
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level_n1: got %0d want 1", level); end
    n_cmp++; if (tx !== 1'b1)    begin n_bad++; $display("FAIL single_tx_n1: got %b want 1", tx); end
    step();
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        n_cmp++; if (tx !== fb[b]) begin n_bad++; $display("FAIL single_bit%0d_cyc%0d: got %b want %b", b, c, tx, fb[b]); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_bit%0d_cyc%0d: got %b want 1", b, c, busy); end
        step();
      end
    end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (tx !== 1'b1)    begin n_bad++; $display("FAIL single_tx_end: got %b want 1", tx); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty_end: got %b want 1", empty); end
    for (int k = 0; k < 20 && mon_q.size() < 1; k++) step();
    n_cmp++; if (mon_q.size() != 1) begin n_bad++; $display("FAIL single_frames: got %0d want 1", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== 8'h55) begin n_bad++; $display("FAIL single_byte: got %h want 55", mon_q[0]); end
    end
    n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL single_monitor_err: got %0d want 0", mon_err); end
    repeat (5) step();
  endtask

  task automatic test_back_to_back();
    mon_q.delete(); mon_par.delete(); mon_err = 0;
    wr_data = 8'hA5; wr_en = 1'b1;
    step();
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL b2b_level_a: got %0d want 1", level); end
    wr_data = 8'h3C;
    step(); wr_en = 1'b0;
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL b2b_level_b: got %0d want 1", level); end
    n_cmp++; if (tx !== 1'b0)    begin n_bad++; $display("FAIL b2b_first_start: got %b want 0", tx); end
    repeat (FRAME-1) step();
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL b2b_last_stop_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_last_stop_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (tx !== 1'b0)    begin n_bad++; $display("FAIL b2b_second_start: got %b want 0", tx); end
    n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL b2b_busy_gap: got %b want 1", busy); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL b2b_level_c: got %0d want 0", level); end
    for (int k = 0; k < 2*FRAME && mon_q.size() < 2; k++) step();
    n_cmp++; if (mon_q.size() != 2) begin n_bad++; $display("FAIL b2b_frames: got %0d want 2", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== 8'hA5) begin n_bad++; $display("FAIL b2b_byte0: got %h want a5", mon_q[0]); end
      n_cmp++; if (mon_q[1] !== 8'h3C) begin n_bad++; $display("FAIL b2b_byte1: got %h want 3c", mon_q[1]); end
    end
    n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL b2b_monitor_err: got %0d want 0", mon_err); end
    repeat (10) step();
  endtask

  task automatic test_overflow();
    mon_q.delete(); mon_par.delete(); mon_err = 0;
    wr_data = 8'hE1; wr_en = 1'b1;
    step(); wr_en = 1'b0;
    step();
    for (int k = 0; k < 9; k++) begin
      wr_data = 8'(k); wr_en = 1'b1;
      if (k == 8) begin
        n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL ovf_full_at8: got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      step();
      if (k < 8) begin
        n_cmp++; if (level !== 4'(k+1)) begin n_bad++; $display("FAIL ovf_level_k%0d: got %0d want %0d", k, level, k+1); end
      end
    end
    wr_en = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (level !== 4'd8)    begin n_bad++; $display("FAIL ovf_level_hold: got %0d want 8", level); end
    n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL ovf_full_hold: got %b want 1", full); end
    for (int k = 0; k < 10*FRAME && mon_q.size() < 9; k++) step();
    repeat (2*FRAME) step();
    n_cmp++; if (mon_q.size() != 9) begin n_bad++; $display("FAIL ovf_frames: got %0d want 9", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== 8'hE1) begin n_bad++; $display("FAIL ovf_first: got %h want e1", mon_q[0]); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (mon_q[i+1] !== 8'(i)) begin n_bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, mon_q[i+1], 8'(i)); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (empty !== 1'b1)    begin n_bad++; $display("FAIL ovf_drained: got %b want 1", empty); end
    n_cmp++; if (mon_err != 0)      begin n_bad++; $display("FAIL ovf_monitor_err: got %0d want 0", mon_err); end
  endtask

  task automatic test_reset_mid();
    int lows, busys;
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf_clear: got %b want 0", overflow); end
    step();
    wr_data = 8'hFF; wr_en = 1'b1;
    step();
    wr_data = 8'h11;
    step(); wr_en = 1'b0;
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rmid_start: got %b want 0", tx); end
    repeat (18) step();
    n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL rmid_level_pre: got %0d want 1", level); end
    rst = 1'b1;
    step(); rst = 1'b0;
    n_cmp++; if (tx !== 1'b1)    begin n_bad++; $display("FAIL rmid_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty: got %b want 1", empty); end
    lows = 0; busys = 0;
    for (int k = 0; k < 3*FRAME; k++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    n_cmp++; if (lows != 0)  begin n_bad++; $display("FAIL rmid_quiet_tx: got %0d low cycles want 0", lows); end
    n_cmp++; if (busys != 0) begin n_bad++; $display("FAIL rmid_quiet_busy: got %0d busy cycles want 0", busys); end
    mon_q.delete(); mon_par.delete(); mon_err = 0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    mon_q.delete(); mon_par.delete(); mon_err = 0;
    wr_data = 8'h07; wr_en = 1'b1;
    step();
    wr_data = 8'h03;
    step(); wr_en = 1'b0;
    for (int k = 0; k < 3*FRAME && mon_q.size() < 2; k++) step();
    n_cmp++; if (mon_q.size() != 2) begin n_bad++; $display("FAIL par_frames: got %0d want 2", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== 8'h07)  begin n_bad++; $display("FAIL par_byte0: got %h want 07", mon_q[0]); end
      n_cmp++; if (mon_q[1] !== 8'h03)  begin n_bad++; $display("FAIL par_byte1: got %h want 03", mon_q[1]); end
      n_cmp++; if (mon_par[0] !== 1'b1) begin n_bad++; $display("FAIL par_bit07: got %b want 1", mon_par[0]); end
      n_cmp++; if (mon_par[1] !== 1'b0) begin n_bad++; $display("FAIL par_bit03: got %b want 0", mon_par[1]); end
    end
    n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL par_monitor_err: got %0d want 0", mon_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, giving clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of byte entries in the TX FIFO (power of two, 2..64).
REQ-003 wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-005 wr_en  input  1  push wr_data into FIFO this cycle.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 empty  output  1  FIFO holds zero entries.
REQ-009 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 overflow  output  1  sticky; set when wr_en is asserted while full.
REQ-011 busy  output  1  high while a frame is on the line (any FSM state other than IDLE).
REQ-012 tx  output  1  serial line; idles high; feeds user GPIO toward the bench UART monitor.

Function
REQ-013 The frame SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity (see Configuration), 1 stop bit (1); each bit held exactly CLK_DIV cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; transitions IDLE->START when FIFO non-empty; START->DATA after CLK_DIV cycles; DATA->PARITY (or STOP if parity compiled out) after the 8th bit; PARITY->STOP; STOP->START if FIFO non-empty at end of stop bit, else IDLE.
REQ-015 A byte written in cycle N to an empty FIFO with FSM in IDLE SHALL cause tx to go low in cycle N+2 (pop in N+1, registered tx in N+2).
REQ-016 Back-to-back frames SHALL have no idle gap: the next start bit begins the cycle after the last stop-bit cycle.
REQ-017 tx SHALL be a registered output, glitch-free.
REQ-018 A write when full SHALL be dropped and set overflow; full is evaluated from the registered count, so a write coinciding with a pop while full is still dropped.
REQ-019 Simultaneous write and pop when not full SHALL leave level unchanged and store the new byte.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH nor underflow.
REQ-021 The bit counter SHALL count 0..CLK_DIV-1 and reload at every bit boundary; the data index SHALL count 0..7.
REQ-022 The byte being shifted SHALL be latched at pop; later FIFO writes SHALL not alter it.

Reset
REQ-023 While wb_rst_i is high at a rising edge: tx=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, pointers and counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame: tx returns high the cycle after the reset edge and FIFO contents are discarded.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, the PARITY state is included and transmits even parity (XOR of the 8 data bits), frame = 11 bits; when undefined, the PARITY state and its logic are absent and the frame = 10 bits.

Verification
REQ-026 CLK_DIV=4, write 0x55 once -> tx low in cycles N+2..N+5, then 1,0,1,0,1,0,1,0 each 4 cycles, then stop high; busy falls after the stop bit (40 cycles total; 44 with parity, parity bit 0).
REQ-027 Write 0xA5, 0x3C on consecutive cycles -> two frames with zero idle cycles between stop of 0xA5 and start of 0x3C; level goes 1,1,0 around the pops.
REQ-028 FIFO_DEPTH=8, write 9 bytes in 9 cycles while the first frame is in progress -> full=1 at 8 entries stored, 9th byte dropped, overflow=1 and sticky; exactly 8 frames (0x00..0x07) observed on tx.
REQ-029 Assert wb_rst_i for 1 cycle in the middle of DATA of 0xFF -> tx=1, busy=0, level=0 next cycle; no further frames.
REQ-030 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; the bench UART monitor decodes both bytes without error.
